// File: rtl/io_seq_checker.sv
// io_seq_checker
//   Steps through a loadable table of expected words, each with a per-bit
//   compare mask, against an observed bus once the DUT reports ready. It
//   reports pass or fail, the failing index and the offending value.
//   The observed bus is registered first, so every compare sees obs one
//   cycle late.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | out of reset, nothing armed
//   ARMED | start accepted, waiting for dut_ready
//   CHECK | awaiting table entry cur_idx on obs_q
//   PASS  | all num_entries entries matched in order
//   FAIL  | strict-order mismatch or per-entry timeout
//
// Ports
//   clock        in   system clock, rising edge
//   resetb       in   asynchronous active-low reset
//   tbl_we       in   table write strobe (ignored while busy)
//   tbl_addr     in   table write address
//   tbl_data     in   expected word
//   tbl_mask     in   compare mask, 1 = bit compared
//   num_entries  in   entries to check, clamped to DEPTH
//   start        in   arm pulse (ignored while busy)
//   dut_ready    in   checking begins once seen high in ARMED
//   obs          in   observed bus
//   busy         out  ARMED or CHECK
//   done         out  PASS or FAIL
//   pass         out  sequence fully matched
//   fail         out  mismatch or timeout
//   timed_out    out  fail caused by timeout
//   cur_idx      out  entry awaited / failing index
//   last_obs     out  registered obs at fail or final match
module io_seq_checker #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 0,
    parameter bit STRICT         = 1'b0,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             tbl_we,
    input  logic [AW-1:0]    tbl_addr,
    input  logic [WIDTH-1:0] tbl_data,
    input  logic [WIDTH-1:0] tbl_mask,
    input  logic [CW-1:0]    num_entries,
    input  logic             start,
    input  logic             dut_ready,
    input  logic [WIDTH-1:0] obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timed_out,
    output logic [AW-1:0]    cur_idx,
    output logic [WIDTH-1:0] last_obs
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LOAD = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_PASS,
        S_FAIL
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] exp_mem  [DEPTH];
    logic [WIDTH-1:0] mask_mem [DEPTH];

    logic [WIDTH-1:0] obs_q, obs_qq;
    logic [CW-1:0]    num_q, num_clamp;
    logic [TW-1:0]    timer;
    logic             first_q, adv_q;
    logic [AW-1:0]    prev_idx;
    logic             match, evt, dup, adv_ok, strict_fail, tmo, last_entry;
    logic             advance, fail_now, start_ok;

    assign busy = (state == S_ARMED) || (state == S_CHECK);
    assign done = (state == S_PASS) || (state == S_FAIL);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);

    assign num_clamp  = (num_entries > CW'(DEPTH)) ? CW'(DEPTH) : num_entries;
    assign start_ok   = start && !busy;
    assign prev_idx   = cur_idx - AW'(1);
    assign last_entry = (CW'(cur_idx) + CW'(1)) == num_q;

    assign match = ((obs_q ^ exp_mem[cur_idx]) & mask_mem[cur_idx]) == '0;
    // In strict mode an unchanged bus is not a new event, but an entry that
    // repeats the one just consumed may still be taken on the next cycle.
    assign evt = first_q || (obs_q != obs_qq);
    assign dup = adv_q && (exp_mem[cur_idx] == exp_mem[prev_idx])
                       && (mask_mem[cur_idx] == mask_mem[prev_idx]);
    assign adv_ok      = match && (!STRICT || evt || dup);
    assign strict_fail = STRICT && evt && !match;
    assign tmo         = (TIMEOUT_CYCLES != 0) && (timer == '0);

    always_ff @(posedge clock) begin
        if (tbl_we && !busy) begin
            exp_mem[tbl_addr]  <= tbl_data;
            mask_mem[tbl_addr] <= tbl_mask;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d  = state;
        advance  = 1'b0;
        fail_now = 1'b0;
        case (state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start) state_d = (num_clamp == '0) ? S_PASS : S_ARMED;
            end
            S_ARMED: begin
                if (dut_ready) state_d = S_CHECK;
            end
            S_CHECK: begin
                // a match in the same cycle as the timeout wins
                if (adv_ok) begin
                    advance = 1'b1;
                    if (last_entry) state_d = S_PASS;
                end else if (strict_fail || tmo) begin
                    fail_now = 1'b1;
                    state_d  = S_FAIL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            obs_q     <= '0;
            obs_qq    <= '0;
            num_q     <= '0;
            timer     <= '0;
            first_q   <= 1'b0;
            adv_q     <= 1'b0;
            timed_out <= 1'b0;
            cur_idx   <= '0;
            last_obs  <= '0;
        end else begin
            obs_q  <= obs;
            obs_qq <= obs_q;
            if (start_ok) begin
                num_q     <= num_clamp;
                timed_out <= 1'b0;
                cur_idx   <= '0;
            end
            if (state == S_ARMED && dut_ready) begin
                cur_idx <= '0;
                timer   <= TMR_LOAD;
                first_q <= 1'b1;
                adv_q   <= 1'b0;
            end
            if (state == S_CHECK) begin
                first_q <= 1'b0;
                adv_q   <= advance;
                if (advance) begin
                    timer <= TMR_LOAD;
                    if (last_entry) last_obs <= obs_q;
                    else            cur_idx  <= cur_idx + AW'(1);
                end else begin
                    if (timer != '0) timer <= timer - TW'(1);
                    if (fail_now) begin
                        last_obs  <= obs_q;
                        timed_out <= !strict_fail;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_io_seq_checker.sv
module tb_io_seq_checker;

    logic        clock = 1'b0;
    logic        resetb;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [15:0] tbl_data, tbl_mask;
    logic [4:0]  num_entries;
    logic        start, dut_ready;
    logic [15:0] obs;

    logic        d_busy, d_done, d_pass, d_fail, d_to;
    logic [3:0]  d_idx;
    logic [15:0] d_last;
    logic        s_busy, s_done, s_pass, s_fail, s_to;
    logic [3:0]  s_idx;
    logic [15:0] s_last;
    logic        t_busy, t_done, t_pass, t_fail, t_to;
    logic [3:0]  t_idx;
    logic [15:0] t_last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    io_seq_checker #(.WIDTH(16), .DEPTH(16), .TIMEOUT_CYCLES(0), .STRICT(1'b0)) u_dflt (
        .clock(clock), .resetb(resetb), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_mask(tbl_mask), .num_entries(num_entries),
        .start(start), .dut_ready(dut_ready), .obs(obs),
        .busy(d_busy), .done(d_done), .pass(d_pass), .fail(d_fail),
        .timed_out(d_to), .cur_idx(d_idx), .last_obs(d_last));

    io_seq_checker #(.WIDTH(16), .DEPTH(16), .TIMEOUT_CYCLES(0), .STRICT(1'b1)) u_strict (
        .clock(clock), .resetb(resetb), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_mask(tbl_mask), .num_entries(num_entries),
        .start(start), .dut_ready(dut_ready), .obs(obs),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
        .timed_out(s_to), .cur_idx(s_idx), .last_obs(s_last));

    io_seq_checker #(.WIDTH(16), .DEPTH(16), .TIMEOUT_CYCLES(100), .STRICT(1'b0)) u_tmo (
        .clock(clock), .resetb(resetb), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_mask(tbl_mask), .num_entries(num_entries),
        .start(start), .dut_ready(dut_ready), .obs(obs),
        .busy(t_busy), .done(t_done), .pass(t_pass), .fail(t_fail),
        .timed_out(t_to), .cur_idx(t_idx), .last_obs(t_last));

    task automatic step();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        resetb = 1'b0;
        tbl_we = 1'b0; start = 1'b0; dut_ready = 1'b0; obs = '0;
        step(); step();
        resetb = 1'b1;
        step();
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d, input logic [15:0] m);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = d; tbl_mask = m;
        step();
        tbl_we = 1'b0;
    endtask

    // start pulse, then dut_ready for one cycle; returns just after CHECK entry
    task automatic arm(input logic [4:0] n);
        num_entries = n;
        start = 1'b1;
        step();
        start = 1'b0; dut_ready = 1'b1;
        step();
        dut_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0; tbl_mask = '0;
        num_entries = '0; start = 1'b0; dut_ready = 1'b0; obs = '0;
        step(); step();
        n_checks++;
        if ({d_busy, d_done, d_pass, d_fail, d_to, d_idx, d_last} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_dflt: got %h expected 0", {d_busy, d_done, d_pass, d_fail, d_to, d_idx, d_last});
        end
        n_checks++;
        if ({s_busy, s_done, s_pass, s_fail, s_to, s_idx, s_last} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_strict: got %h expected 0", {s_busy, s_done, s_pass, s_fail, s_to, s_idx, s_last});
        end
        n_checks++;
        if ({t_busy, t_done, t_pass, t_fail, t_to, t_idx, t_last} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_tmo: got %h expected 0", {t_busy, t_done, t_pass, t_fail, t_to, t_idx, t_last});
        end
        resetb = 1'b1;
        step();
    endtask

    task automatic test_basic();
        apply_reset();
        load(4'd0, 16'h5823, 16'hFFFF);
        load(4'd1, 16'hD823, 16'hFFFF);
        load(4'd2, 16'h3C5F, 16'hFFFF);
        arm(5'd3);
        n_checks++;
        if (d_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", d_busy); end
        obs = 16'h5823; step();
        n_checks++;
        if (d_idx !== 4'd0) begin n_fail++; $display("FAIL basic_idx0: got %0d expected 0", d_idx); end
        obs = 16'hD823; step();
        n_checks++;
        if (d_idx !== 4'd1) begin n_fail++; $display("FAIL basic_idx1: got %0d expected 1", d_idx); end
        obs = 16'h3C5F; step();
        n_checks++;
        if ({d_idx, d_pass} !== {4'd2, 1'b0}) begin
            n_fail++; $display("FAIL basic_idx2: got idx %0d pass %b expected idx 2 pass 0", d_idx, d_pass);
        end
        step();
        n_checks++;
        if ({d_pass, d_done, d_busy, d_fail, d_to} !== 5'b11000) begin
            n_fail++; $display("FAIL basic_flags: got %b expected 11000", {d_pass, d_done, d_busy, d_fail, d_to});
        end
        n_checks++;
        if ({d_idx, d_last} !== {4'd2, 16'h3C5F}) begin
            n_fail++; $display("FAIL basic_result: got idx %0d last %h expected idx 2 last 3c5f", d_idx, d_last);
        end
    endtask

    task automatic test_dup_wait();
        apply_reset();
        load(4'd0, 16'hDCD9, 16'hFFFF);
        load(4'd1, 16'hDCD9, 16'hFFFF);
        load(4'd2, 16'hDF09, 16'hFFFF);
        arm(5'd3);
        obs = 16'h1111; step();
        obs = 16'hDCD9; step();
        n_checks++;
        if (d_idx !== 4'd0) begin n_fail++; $display("FAIL dup_ignore: got %0d expected 0", d_idx); end
        step();
        n_checks++;
        if (d_idx !== 4'd1) begin n_fail++; $display("FAIL dup_idx1: got %0d expected 1", d_idx); end
        obs = 16'hDF09; step();
        n_checks++;
        if (d_idx !== 4'd2) begin n_fail++; $display("FAIL dup_idx2: got %0d expected 2", d_idx); end
        step();
        n_checks++;
        if ({d_pass, d_last} !== {1'b1, 16'hDF09}) begin
            n_fail++; $display("FAIL dup_pass: got pass %b last %h expected pass 1 last df09", d_pass, d_last);
        end
    endtask

    task automatic test_strict_fail();
        apply_reset();
        load(4'd0, 16'h5823, 16'hFFFF);
        load(4'd1, 16'hD823, 16'hFFFF);
        obs = 16'h5823;
        arm(5'd2);
        step();
        n_checks++;
        if ({s_idx, s_fail} !== {4'd1, 1'b0}) begin
            n_fail++; $display("FAIL strict_adv: got idx %0d fail %b expected idx 1 fail 0", s_idx, s_fail);
        end
        obs = 16'h1234; step();
        n_checks++;
        if (s_fail !== 1'b0) begin n_fail++; $display("FAIL strict_hold: got fail %b expected 0", s_fail); end
        step();
        n_checks++;
        if ({s_fail, s_to, s_pass, s_idx, s_last} !== {3'b100, 4'd1, 16'h1234}) begin
            n_fail++;
            $display("FAIL strict_result: got fail %b to %b pass %b idx %0d last %h expected 1 0 0 1 1234",
                     s_fail, s_to, s_pass, s_idx, s_last);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        load(4'd0, 16'h0001, 16'hFFFF);
        arm(5'd1);
        repeat (99) step();
        n_checks++;
        if ({t_fail, t_busy} !== 2'b01) begin
            n_fail++; $display("FAIL tmo_early: got fail %b busy %b expected fail 0 busy 1", t_fail, t_busy);
        end
        step();
        n_checks++;
        if ({t_fail, t_to, t_idx, t_last} !== {2'b11, 4'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL tmo_result: got fail %b to %b idx %0d last %h expected 1 1 0 0000", t_fail, t_to, t_idx, t_last);
        end
        // a match on the final allowed cycle beats the timeout
        apply_reset();
        load(4'd0, 16'h0001, 16'hFFFF);
        load(4'd1, 16'h0002, 16'hFFFF);
        arm(5'd2);
        repeat (98) step();
        obs = 16'h0001; step();
        step();
        n_checks++;
        if ({t_fail, t_idx} !== {1'b0, 4'd1}) begin
            n_fail++; $display("FAIL tmo_matchwins: got fail %b idx %0d expected fail 0 idx 1", t_fail, t_idx);
        end
        obs = 16'h0002; step();
        step();
        n_checks++;
        if ({t_pass, t_to} !== 2'b10) begin
            n_fail++; $display("FAIL tmo_pass: got pass %b to %b expected pass 1 to 0", t_pass, t_to);
        end
    endtask

    task automatic test_mask();
        apply_reset();
        load(4'd0, 16'h5800, 16'hFF00);
        load(4'd1, 16'h5800, 16'hFF00);
        obs = 16'h58AB;
        arm(5'd2);
        step();
        n_checks++;
        if (s_idx !== 4'd1) begin n_fail++; $display("FAIL mask_match: got idx %0d expected 1", s_idx); end
        step();
        n_checks++;
        if ({s_pass, s_last} !== {1'b1, 16'h58AB}) begin
            n_fail++; $display("FAIL mask_duppass: got pass %b last %h expected pass 1 last 58ab", s_pass, s_last);
        end
        obs = 16'h59AB;
        arm(5'd1);
        n_checks++;
        if ({s_pass, s_busy} !== 2'b01) begin
            n_fail++; $display("FAIL mask_rerun: got pass %b busy %b expected pass 0 busy 1", s_pass, s_busy);
        end
        step();
        n_checks++;
        if ({s_fail, s_to, s_idx, s_last} !== {2'b10, 4'd0, 16'h59AB}) begin
            n_fail++;
            $display("FAIL mask_nomatch: got fail %b to %b idx %0d last %h expected 1 0 0 59ab", s_fail, s_to, s_idx, s_last);
        end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        load(4'd0, 16'h5823, 16'hFFFF);
        load(4'd1, 16'hD823, 16'hFFFF);
        load(4'd2, 16'h3C5F, 16'hFFFF);
        arm(5'd3);
        obs = 16'h5823; step();
        obs = 16'hD823; step();
        #2 resetb = 1'b0;
        #1;
        n_checks++;
        if ({d_busy, d_done, d_pass, d_fail, d_to, d_idx, d_last} !== 25'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h expected 0", {d_busy, d_done, d_pass, d_fail, d_to, d_idx, d_last});
        end
        step();
        resetb = 1'b1; obs = '0;
        step();
        n_checks++;
        if (d_busy !== 1'b0) begin n_fail++; $display("FAIL midrun_idle: got busy %b expected 0", d_busy); end
        arm(5'd3);
        obs = 16'h5823; step();
        obs = 16'hD823; step();
        start = 1'b1;
        tbl_we = 1'b1; tbl_addr = 4'd2; tbl_data = 16'h0000; tbl_mask = 16'hFFFF;
        step();
        start = 1'b0; tbl_we = 1'b0;
        n_checks++;
        if ({d_busy, d_idx} !== {1'b1, 4'd2}) begin
            n_fail++; $display("FAIL busy_start_ignored: got busy %b idx %0d expected busy 1 idx 2", d_busy, d_idx);
        end
        obs = 16'h3C5F; step();
        step();
        n_checks++;
        if ({d_pass, d_last} !== {1'b1, 16'h3C5F}) begin
            n_fail++; $display("FAIL rerun_pass: got pass %b last %h expected pass 1 last 3c5f", d_pass, d_last);
        end
    endtask

    task automatic test_zero_entries();
        apply_reset();
        num_entries = 5'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({d_pass, d_busy, d_fail} !== 3'b100) begin
            n_fail++; $display("FAIL zero_entries: got pass %b busy %b fail %b expected 1 0 0", d_pass, d_busy, d_fail);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dup_wait();
        test_strict_fail();
        test_timeout();
        test_mask();
        test_reset_midrun();
        test_zero_entries();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
